// File: rtl/axis_lockstep_join_pkg.sv
// Shared types and width helpers for the lockstep AXI4-Stream join.
package axis_lockstep_join_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } join_state_e;

  localparam int unsigned BITS_PER_KEEP = 8;

  function automatic int unsigned keep_bits(input int unsigned data_w);
    return (data_w + BITS_PER_KEEP - 1) / BITS_PER_KEEP;
  endfunction

  // One lane's slice of the packed payload: data + keep + user.
  function automatic int unsigned lane_bits(input int unsigned data_w,
                                            input int unsigned keep_w,
                                            input int unsigned user_w);
    return data_w + keep_w + user_w;
  endfunction

endpackage

// File: rtl/axis_lockstep_join_skid.sv
// Output register plus one-entry skid buffer; out_ready is registered so the
// upstream join never sees a combinational path from m_ready.
module axis_lockstep_join_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             out_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             ready_q, ready_d;
  logic             m_valid_q, m_valid_d;
  logic             temp_valid_q, temp_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] temp_data_q, temp_data_d;

  always_comb begin
    // Stay ready if the sink drains, or the skid is free and nothing new is
    // about to collide with a held output beat.
    ready_d      = m_ready | (~temp_valid_q & (~m_valid_q | ~in_valid));
    m_valid_d    = m_valid_q;
    temp_valid_d = temp_valid_q;
    m_data_d     = m_data_q;
    temp_data_d  = temp_data_q;
    if (ready_q) begin
      if (m_ready | ~m_valid_q) begin
        m_valid_d = in_valid;
        if (in_valid) m_data_d = in_data;
      end else begin
        temp_valid_d = in_valid;
        if (in_valid) temp_data_d = in_data;
      end
    end else if (m_ready) begin
      m_valid_d    = temp_valid_q;
      m_data_d     = temp_data_q;
      temp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      m_valid_q    <= 1'b0;
      temp_valid_q <= 1'b0;
      m_data_q     <= '0;
      temp_data_q  <= '0;
    end else begin
      ready_q      <= ready_d;
      m_valid_q    <= m_valid_d;
      temp_valid_q <= temp_valid_d;
      m_data_q     <= m_data_d;
      temp_data_q  <= temp_data_d;
    end
  end

  assign out_ready = ready_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;

endmodule

// File: rtl/axis_lockstep_join.sv
// Lockstep join of S_COUNT AXI4-Stream lanes with misalignment recovery.
// Define AXIS_LOCKSTEP_JOIN_ERR_CNT_EN to build the saturating err_count.
module axis_lockstep_join
  import axis_lockstep_join_pkg::*;
#(
  parameter int unsigned S_COUNT       = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter bit          KEEP_ENABLE   = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH    = ((DATA_WIDTH + 7) / 8),
  parameter bit          USER_ENABLE   = 1'b1,
  parameter int unsigned USER_WIDTH    = 1,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [S_COUNT-1:0]             s_axis_tvalid,
  output logic [S_COUNT-1:0]             s_axis_tready,
  input  logic [S_COUNT-1:0]             s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [S_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [S_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [S_COUNT*USER_WIDTH-1:0]  m_axis_tuser,
  output logic                           err_mismatch,
  output logic [ERR_CNT_WIDTH-1:0]       err_count
);

  localparam int unsigned DW_ALL = S_COUNT * DATA_WIDTH;
  localparam int unsigned KW_ALL = S_COUNT * KEEP_WIDTH;
  localparam int unsigned UW_ALL = S_COUNT * USER_WIDTH;
  localparam int unsigned BUS_W  = S_COUNT * lane_bits(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH) + 1;

  join_state_e        state_q, state_d;
  logic [S_COUNT-1:0] done_q, done_d;
  logic               err_q, err_d;

  logic               out_ready;
  logic               all_valid, in_valid, accept;
  logic               last_any, last_mixed, mismatch;
  logic [KW_ALL-1:0]  keep_join;
  logic [UW_ALL-1:0]  user_join;
  logic [BUS_W-1:0]   in_bus, out_bus;

  always_comb begin
    all_valid  = &s_axis_tvalid;
    in_valid   = (state_q == ST_RUN) & all_valid;
    accept     = in_valid & out_ready;
    last_any   = |s_axis_tlast;
    last_mixed = last_any & ~(&s_axis_tlast);
    mismatch   = accept & last_mixed;
  end

  always_comb begin
    keep_join = KEEP_ENABLE ? s_axis_tkeep : '1;
    user_join = '0;
    if (USER_ENABLE) begin
      user_join = s_axis_tuser;
      // A mixed-tlast beat closes the frame, so every lane flags it bad.
      if (last_mixed) begin
        for (int unsigned i = 0; i < S_COUNT; i++) begin
          user_join[i*USER_WIDTH] = 1'b1;
        end
      end
    end
    in_bus = {last_any, user_join, keep_join, s_axis_tdata};
  end

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    err_d         = mismatch;
    s_axis_tready = '0;
    case (state_q)
      ST_RUN: begin
        s_axis_tready = {S_COUNT{all_valid & out_ready}};
        if (mismatch) begin
          state_d = ST_DRAIN;
          done_d  = s_axis_tlast;
        end
      end
      ST_DRAIN: begin
        s_axis_tready = ~done_q;
        if (&done_q) begin
          state_d = ST_RUN;
          done_d  = '0;
        end else begin
          done_d = done_q | (s_axis_tvalid & ~done_q & s_axis_tlast);
        end
      end
      default: begin
        state_d = ST_RUN;
        done_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign err_mismatch = err_q;

`ifdef AXIS_LOCKSTEP_JOIN_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (mismatch && (cnt_q != '1)) cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`else
  assign err_count = '0;
`endif

  axis_lockstep_join_skid #(
    .WIDTH (BUS_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_bus),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .m_data    (out_bus),
    .m_valid   (m_axis_tvalid),
    .m_ready   (m_axis_tready)
  );

  assign m_axis_tdata = out_bus[DW_ALL-1:0];
  assign m_axis_tkeep = out_bus[DW_ALL +: KW_ALL];
  assign m_axis_tuser = out_bus[DW_ALL+KW_ALL +: UW_ALL];
  assign m_axis_tlast = out_bus[BUS_W-1];

endmodule

// File: tb/tb_axis_lockstep_join.sv
// Directed bench for axis_lockstep_join: per-lane source queues feed the DUT,
// a frame-level join model predicts output beats and mismatch count.
module tb_axis_lockstep_join;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S*DW-1:0] s_tdata = '0;
  logic [S-1:0]    s_tkeep = '0;
  logic [S-1:0]    s_tvalid = '0;
  logic [S-1:0]    s_tready;
  logic [S-1:0]    s_tlast = '0;
  logic [S-1:0]    s_tuser = '0;
  logic [S*DW-1:0] m_tdata;
  logic [S-1:0]    m_tkeep;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic [S-1:0]    m_tuser;
  logic            err_mismatch;
  logic [CW-1:0]   err_count;

  always #5 clk = ~clk;

  axis_lockstep_join #(
    .S_COUNT       (S),
    .DATA_WIDTH    (DW),
    .ERR_CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .err_mismatch  (err_mismatch),
    .err_count     (err_count)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [3:0]  u;
    logic        bad;
  } obeat_t;

  beat_t  src_q [S][$];
  beat_t  mdl_q [S][$];
  bit     mdl_disc [S];
  obeat_t exp_q [$];

  int     checks = 0;
  int     errors = 0;
  int     hold [S];
  bit     acc [S];
  int     mode = 0;
  int     cyc = 0;
  int     pulses = 0;
  int     mdl_errs = 0;
  int     out_beats = 0;
  bit     prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [3:0]  prev_user;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int lane, input int n, input logic [7:0] base, input logic u0);
    for (int b = 0; b < n; b++) begin
      beat_t x;
      x.d = base + 8'(b);
      x.l = (b == n - 1);
      x.u = u0 ^ b[0];
      src_q[lane].push_back(x);
      mdl_q[lane].push_back(x);
    end
  endtask

  function automatic bit any_disc();
    bit r = 0;
    for (int i = 0; i < S; i++) r |= mdl_disc[i];
    return r;
  endfunction

  function automatic bit all_have();
    bit r = 1;
    for (int i = 0; i < S; i++) if (mdl_q[i].size() == 0) r = 0;
    return r;
  endfunction

  function automatic bit src_busy();
    bit r = 0;
    for (int i = 0; i < S; i++) if (src_q[i].size() != 0) r = 1;
    return r;
  endfunction

  // Frame-level join: pair one beat per lane; on mixed tlast emit a bad
  // frame end and throw away the rest of each still-open lane frame.
  task automatic model_run();
    bit moved;
    do begin
      moved = 0;
      for (int i = 0; i < S; i++) begin
        while (mdl_disc[i] && mdl_q[i].size() > 0) begin
          beat_t x;
          x = mdl_q[i].pop_front();
          if (x.l) mdl_disc[i] = 0;
          moved = 1;
        end
      end
      if (!any_disc() && all_have()) begin
        obeat_t o;
        bit     lastv [S];
        int     nl;
        nl = 0;
        for (int i = 0; i < S; i++) begin
          beat_t x;
          x = mdl_q[i].pop_front();
          o.d[i*8 +: 8] = x.d;
          o.u[i] = x.u;
          lastv[i] = x.l;
          if (x.l) nl++;
        end
        if (nl == 0) begin
          o.l = 0; o.bad = 0;
        end else if (nl == S) begin
          o.l = 1; o.bad = 0;
        end else begin
          o.l = 1; o.bad = 1; o.u = 4'hF;
          mdl_errs++;
          for (int i = 0; i < S; i++) if (!lastv[i]) mdl_disc[i] = 1;
        end
        exp_q.push_back(o);
        moved = 1;
      end
    end while (moved);
  endtask

  task automatic compare();
    if (err_mismatch === 1'b1) pulses++;
    if (prev_stall) begin
      chk("stall_valid", m_tvalid, 1);
      chk("stall_data", m_tdata, prev_data);
      chk("stall_last", m_tlast, prev_last);
      chk("stall_user", m_tuser, prev_user);
    end
    if (mode == 0) begin
      chk("err_align", err_mismatch,
          (m_tvalid && exp_q.size() > 0) ? exp_q[0].bad : 1'b0);
    end
    if (m_tvalid && m_tready) begin
      out_beats++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_tdata, 0);
      end else begin
        obeat_t e;
        e = exp_q.pop_front();
        chk("out_data", m_tdata, e.d);
        chk("out_last", m_tlast, e.l);
        chk("out_user", m_tuser, e.u);
        chk("out_keep", m_tkeep, 4'hF);
      end
    end
    prev_stall = m_tvalid & ~m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    prev_user  = m_tuser;
  endtask

  // One clock: retire last cycle's handshakes, drive fronts, sample, compare.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < S; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      acc[i] = 0;
    end
    cyc++;
    m_tready = (mode == 0) ? 1'b1 : cyc[0];
    for (int i = 0; i < S; i++) begin
      if (hold[i] > 0) begin
        hold[i]--;
        s_tvalid[i] = 0; s_tdata[i*8 +: 8] = '0; s_tlast[i] = 0; s_tuser[i] = 0;
      end else if (src_q[i].size() > 0) begin
        s_tvalid[i] = 1;
        s_tdata[i*8 +: 8] = src_q[i][0].d;
        s_tlast[i] = src_q[i][0].l;
        s_tuser[i] = src_q[i][0].u;
      end else begin
        s_tvalid[i] = 0; s_tdata[i*8 +: 8] = '0; s_tlast[i] = 0; s_tuser[i] = 0;
      end
    end
    #1;
    if (rst_n) for (int i = 0; i < S; i++) acc[i] = s_tvalid[i] & s_tready[i];
    compare();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((src_busy() || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, (src_busy() || exp_q.size() > 0) ? 1 : 0, 0);
    repeat (3) step();
  endtask

  task automatic check_err(input string name);
    chk({name, "_pulses"}, pulses, mdl_errs);
`ifdef AXIS_LOCKSTEP_JOIN_ERR_CNT_EN
    chk({name, "_cnt"}, err_count, (mdl_errs > 15) ? 15 : mdl_errs);
`else
    chk({name, "_cnt"}, err_count, 0);
`endif
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < S; i++) begin hold[i] = 0; acc[i] = 0; mdl_disc[i] = 0; end

    // Reset values
    step(); step();
    chk("rst_tready", s_tready, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_mlast", m_tlast, 0);
    chk("rst_mdata", m_tdata, 0);
    chk("rst_mkeep", m_tkeep, 0);
    chk("rst_muser", m_tuser, 0);
    chk("rst_err", err_mismatch, 0);
    chk("rst_cnt", err_count, 0);

    // Aligned 3-beat frames
    for (int i = 0; i < S; i++) push_frame(i, 3, 8'(16 * i), 1'b0);
    model_run();
    chk("t1_model_n", exp_q.size(), 3);
    chk("t1_model_b0", exp_q[0].d, 32'h30201000);
    chk("t1_model_b1", exp_q[1].d, 32'h31211101);
    chk("t1_model_b2", exp_q[2].d, 32'h32221202);
    chk("t1_model_last", {exp_q[0].l, exp_q[1].l, exp_q[2].l}, 3'b001);
    chk("t1_model_user1", exp_q[1].u, 4'hF);
    release_reset();
    step();
    chk("t1_ready_edge0", s_tready, 4'h0);
    step();
    chk("t1_ready_edge1", s_tready, 4'hF);
    chk("t1_mvalid_edge1", m_tvalid, 0);
    step();
    chk("t1_mvalid_edge2", m_tvalid, 1);
    chk("t1_mdata_edge2", m_tdata, 32'h30201000);
    run_idle("t1", 30);
    check_err("t1");

    // Lane 2 valid late
    for (int i = 0; i < S; i++) push_frame(i, 1, 8'(8'hA0 + i), 1'b0);
    model_run();
    hold[2] = 5;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_ready_wait", s_tready, 4'h0);
    end
    step();
    chk("t2_ready_go", s_tready, 4'hF);
    chk("t2_mvalid_pre", m_tvalid, 0);
    step();
    chk("t2_mvalid", m_tvalid, 1);
    chk("t2_mdata", m_tdata, 32'hA3A2A1A0);
    chk("t2_mlast", m_tlast, 1);
    run_idle("t2", 30);

    // Output backpressure toggling every cycle
    out_beats = 0;
    mode = 1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < S; i++) push_frame(i, 4, 8'(64 * i + 16 * f), 1'b0);
    model_run();
    run_idle("t3", 200);
    chk("t3_beats", out_beats, 12);
    mode = 0;
    repeat (2) step();
    check_err("t3");

    // Lane 1 frame short by two beats, then a clean frame
    for (int i = 0; i < S; i++) push_frame(i, (i == 1) ? 2 : 4, 8'(16 * i), 1'b0);
    for (int i = 0; i < S; i++) push_frame(i, 2, 8'(8'h80 + 16 * i), 1'b0);
    model_run();
    chk("t4_model_n", exp_q.size(), 4);
    chk("t4_model_bad_data", exp_q[1].d, 32'h31211101);
    chk("t4_model_bad_last", exp_q[1].l, 1);
    chk("t4_model_bad_user", exp_q[1].u, 4'hF);
    chk("t4_model_next", exp_q[2].d, 32'hB0A09080);
    chk("t4_model_errs", mdl_errs, 1);
    run_idle("t4", 40);
    check_err("t4");

    // Repeated mismatches saturate the counter
    for (int k = 0; k < 19; k++)
      for (int i = 0; i < S; i++) push_frame(i, (i == 0) ? 1 : 2, 8'(k * 4), 1'b1);
    model_run();
    chk("t5_model_errs", mdl_errs, 20);
    run_idle("t5", 400);
    check_err("t5");

    // Reset while draining
    push_frame(0, 1, 8'h11, 1'b0);
    for (int i = 1; i < S; i++) push_frame(i, 4, 8'(8'h20 * i), 1'b0);
    model_run();
    for (int k = 0; k < 12 && err_mismatch !== 1'b1; k++) step();
    chk("t6_mismatch_seen", err_mismatch, 1);
    step();
    chk("t6_drain_ready", s_tready, 4'hE);
    check_err("t6_pre");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tready", s_tready, 0);
    chk("t6_rst_mvalid", m_tvalid, 0);
    chk("t6_rst_mlast", m_tlast, 0);
    chk("t6_rst_mdata", m_tdata, 0);
    chk("t6_rst_muser", m_tuser, 0);
    chk("t6_rst_err", err_mismatch, 0);
    chk("t6_rst_cnt", err_count, 0);
    for (int i = 0; i < S; i++) begin
      src_q[i].delete(); mdl_q[i].delete(); mdl_disc[i] = 0; acc[i] = 0; hold[i] = 0;
    end
    exp_q.delete();
    pulses = 0;
    mdl_errs = 0;
    prev_stall = 0;
    step(); step();
    release_reset();
    for (int i = 0; i < S; i++) push_frame(i, 1, 8'(8'hC0 + i), 1'b0);
    model_run();
    step();
    chk("t6_ready_edge0", s_tready, 4'h0);
    step();
    chk("t6_ready_edge1", s_tready, 4'hF);
    step();
    chk("t6_mdata", m_tdata, 32'hC3C2C1C0);
    run_idle("t6", 30);
    check_err("t6_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
